// File: rtl/index_extractor_pkg.sv
// -----------------------------------------------------------------------------
// index_extractor_pkg
// Shared definitions for the cache-index extractor: default address split
// (byte-offset / set-index widths) and the layout of the 128-bit request
// descriptor pushed to the downstream FIFO.
//   [127:96] request ID
//   [95:64]  byte address
//   [63:32]  tag (address >> (OFFSET_BITS + INDEX_BITS))
//   [31:5]   zero
//   [4]      1 = write, 0 = read
//   [3:0]    set index
// -----------------------------------------------------------------------------
package index_extractor_pkg;

    localparam int OFFSET_BITS    = 6;
    localparam int INDEX_BITS     = 4;

    localparam int DESC_W         = 128;
    localparam int DESC_ID_LSB    = 96;
    localparam int DESC_ADDR_LSB  = 64;
    localparam int DESC_TAG_LSB   = 32;
    localparam int DESC_WR_BIT    = 4;
    localparam int DESC_INDEX_LSB = 0;
    localparam int DESC_INDEX_W   = 4;

    typedef struct packed {
        logic [31:0]             id;
        logic [31:0]             addr;
        logic [31:0]             tag;
        logic [26:0]             rsvd;
        logic                    is_write;
        logic [DESC_INDEX_W-1:0] index;
    } desc_t;

endpackage

// File: rtl/index_extractor_if.sv
// -----------------------------------------------------------------------------
// index_extractor_if
// Bundles the read/write request channels, the extracted index and the
// downstream FIFO push port of index_extractor.
//   master : requester / FIFO side (drives requests and fifo_afull_i)
//   slave  : index_extractor side (drives readies, index_o and FIFO push)
// -----------------------------------------------------------------------------
interface index_extractor_if #(
    parameter int INDEX_BITS = index_extractor_pkg::INDEX_BITS
);
    import index_extractor_pkg::*;

    logic [31:0]           arid_i;
    logic [31:0]           araddr_i;
    logic                  arvalid_i;
    logic                  arready_o;
    logic [31:0]           awid_i;
    logic [31:0]           awaddr_i;
    logic                  awvalid_i;
    logic                  awready_o;
    logic [INDEX_BITS-1:0] index_o;
    logic                  fifo_afull_i;
    logic                  fifo_write_en_o;
    logic [DESC_W-1:0]     fifo_data_o;

    modport master (
        output arid_i, araddr_i, arvalid_i,
        output awid_i, awaddr_i, awvalid_i,
        output fifo_afull_i,
        input  arready_o, awready_o, index_o,
        input  fifo_write_en_o, fifo_data_o
    );

    modport slave (
        input  arid_i, araddr_i, arvalid_i,
        input  awid_i, awaddr_i, awvalid_i,
        input  fifo_afull_i,
        output arready_o, awready_o, index_o,
        output fifo_write_en_o, fifo_data_o
    );

endinterface

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin arbiter (read vs write) with combinational grants.
//   clk, rst_n     : clock, asynchronous active-low reset
//   req_rd, req_wr : request valids
//   enable         : grants allowed this cycle (downstream has room)
//   gnt_rd, gnt_wr : one-hot-or-zero grants; a grant is an accepted handshake
// last_grant records the channel granted most recently (0 = read, 1 = write).
// primed stays low until the first grant after reset so that read leads the
// very first contention even though last_grant resets to 0.
// -----------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req_rd,
    input  logic req_wr,
    input  logic enable,
    output logic gnt_rd,
    output logic gnt_wr
);

    logic last_grant;
    logic primed;

    always_comb begin
        gnt_rd = 1'b0;
        gnt_wr = 1'b0;
        // rst_n gating keeps both readies low while reset is held
        if (enable && rst_n) begin
            if (req_rd && req_wr) begin
                gnt_rd = !primed || last_grant;
                gnt_wr = primed && !last_grant;
            end else begin
                gnt_rd = req_rd;
                gnt_wr = req_wr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b0;
            primed     <= 1'b0;
        end else if (gnt_rd || gnt_wr) begin
            last_grant <= gnt_wr;
            primed     <= 1'b1;
        end
    end

endmodule

// File: rtl/index_extractor.sv
// -----------------------------------------------------------------------------
// index_extractor
// Accepts at most one read or write request per cycle (round-robin when both
// are pending, nothing while the downstream FIFO is almost full), splits the
// accepted byte address into set index and tag, and pushes a 128-bit
// descriptor to the FIFO one cycle after acceptance.
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : index_extractor_if.slave (request channels, index_o, FIFO push)
// -----------------------------------------------------------------------------
module index_extractor #(
    parameter int OFFSET_BITS = index_extractor_pkg::OFFSET_BITS,
    parameter int INDEX_BITS  = index_extractor_pkg::INDEX_BITS
) (
    input  logic               clk,
    input  logic               rst_n,
    index_extractor_if.slave   bus
);
    import index_extractor_pkg::*;

    localparam int TAG_SHIFT = OFFSET_BITS + INDEX_BITS;

    logic                  gnt_rd;
    logic                  gnt_wr;
    logic                  vld_p0;
    logic [31:0]           addr_p0;
    logic [31:0]           id_p0;
    logic [INDEX_BITS-1:0] index_p0;
    logic [31:0]           tag_p0;
    logic [DESC_W-1:0]     desc_p0;

    logic                  vld_p1;
    logic [INDEX_BITS-1:0] index_p1;
    desc_t                 desc_p1;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_rd (bus.arvalid_i),
        .req_wr (bus.awvalid_i),
        .enable (!bus.fifo_afull_i),
        .gnt_rd (gnt_rd),
        .gnt_wr (gnt_wr)
    );

    assign bus.arready_o = gnt_rd;
    assign bus.awready_o = gnt_wr;

    // ---- p0: select granted channel, split address, build descriptor ----
    assign vld_p0   = gnt_rd || gnt_wr;
    assign addr_p0  = gnt_wr ? bus.awaddr_i : bus.araddr_i;
    assign id_p0    = gnt_wr ? bus.awid_i   : bus.arid_i;
    assign index_p0 = addr_p0[TAG_SHIFT-1:OFFSET_BITS];
    assign tag_p0   = addr_p0 >> TAG_SHIFT;

    always_comb begin
        desc_p0                                     = '0;
        desc_p0[DESC_ID_LSB +: 32]                  = id_p0;
        desc_p0[DESC_ADDR_LSB +: 32]                = addr_p0;
        desc_p0[DESC_TAG_LSB +: 32]                 = tag_p0;
        desc_p0[DESC_WR_BIT]                        = gnt_wr;
        desc_p0[DESC_INDEX_LSB +: DESC_INDEX_W]     = DESC_INDEX_W'(index_p0);
    end

    // ---- p1: registered push strobe, descriptor and index ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            index_p1 <= '0;
            desc_p1  <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                index_p1 <= index_p0;
                desc_p1  <= desc_t'(desc_p0);
            end
        end
    end

    assign bus.fifo_write_en_o = vld_p1;
    assign bus.fifo_data_o     = desc_p1;
    assign bus.index_o         = index_p1;

endmodule

// File: tb/tb_index_extractor.sv
// -----------------------------------------------------------------------------
// tb_index_extractor
// Directed scenarios followed by randomized traffic, checked against a
// behavioural model of the request acceptance and descriptor contents.
// -----------------------------------------------------------------------------
module tb_index_extractor;
    import index_extractor_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    index_extractor_if bus ();

    index_extractor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model state: channel granted most recently (-1 none, 0 read, 1 write)
    int           m_last;
    logic         m_wen;
    logic [3:0]   m_idx;
    logic [127:0] m_data;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = -1;
        m_wen  = 1'b0;
        m_idx  = '0;
        m_data = '0;
    endtask

    task automatic drive(input logic arv, input logic [31:0] arid, input logic [31:0] araddr,
                         input logic awv, input logic [31:0] awid, input logic [31:0] awaddr,
                         input logic afull);
        bus.arvalid_i    = arv;
        bus.arid_i       = arid;
        bus.araddr_i     = araddr;
        bus.awvalid_i    = awv;
        bus.awid_i       = awid;
        bus.awaddr_i     = awaddr;
        bus.fifo_afull_i = afull;
    endtask

    // One clock: predict and check readies, then check the registered outputs.
    task automatic cycle(input string tag);
        int          pick;   // 0 none, 1 read, 2 write
        logic [31:0] addr;
        logic [31:0] id;
        pick = 0;
        if (!bus.fifo_afull_i) begin
            if (bus.arvalid_i && bus.awvalid_i) pick = (m_last == 0) ? 2 : 1;
            else if (bus.arvalid_i)             pick = 1;
            else if (bus.awvalid_i)             pick = 2;
        end
        #1;
        chk({tag, "_arready"}, 128'(bus.arready_o), 128'(pick == 1));
        chk({tag, "_awready"}, 128'(bus.awready_o), 128'(pick == 2));
        if (pick != 0) begin
            addr   = (pick == 1) ? bus.araddr_i : bus.awaddr_i;
            id     = (pick == 1) ? bus.arid_i   : bus.awid_i;
            m_idx  = 4'((addr / 32'd64) % 32'd16);
            m_data = {id, addr, addr / 32'd1024, 27'd0, (pick == 2), m_idx};
            m_last = pick - 1;
            m_wen  = 1'b1;
        end else begin
            m_wen  = 1'b0;
        end
        @(posedge clk);
        #1;
        chk({tag, "_wen"},  128'(bus.fifo_write_en_o), 128'(m_wen));
        chk({tag, "_idx"},  128'(bus.index_o),         128'(m_idx));
        chk({tag, "_data"}, bus.fifo_data_o,           m_data);
    endtask

    logic [3:0] held_idx;

    initial begin
        model_reset();
        drive(1'b1, 32'd1, 32'h40, 1'b1, 32'd2, 32'h80, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_wen",     128'(bus.fifo_write_en_o), 128'd0);
        chk("rst_idx",     128'(bus.index_o),         128'd0);
        chk("rst_data",    bus.fifo_data_o,           128'd0);
        chk("rst_arready", 128'(bus.arready_o),       128'd0);
        chk("rst_awready", 128'(bus.awready_o),       128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Contention from reset: read, write, read
        drive(1'b1, 32'd11, 32'd200, 1'b1, 32'd22, 32'd140, 1'b0);
        cycle("rr0");
        chk("rr0_const_idx", 128'(bus.index_o), 128'd3);
        chk("rr0_const_wr",  128'(bus.fifo_data_o[4]), 128'd0);
        cycle("rr1");
        chk("rr1_const_idx", 128'(bus.index_o), 128'd2);
        chk("rr1_const_wr",  128'(bus.fifo_data_o[4]), 128'd1);
        cycle("rr2");
        chk("rr2_const_idx", 128'(bus.index_o), 128'd3);

        // Read only
        drive(1'b1, 32'd5, 32'h1C0, 1'b0, 32'd0, 32'd0, 1'b0);
        cycle("rd");
        chk("rd_const_idx", 128'(bus.index_o),           128'd7);
        chk("rd_const_wr",  128'(bus.fifo_data_o[4]),    128'd0);
        chk("rd_const_tag", 128'(bus.fifo_data_o[63:32]), 128'd0);
        chk("rd_const_id",  128'(bus.fifo_data_o[127:96]), 128'd5);

        // Write only
        drive(1'b0, 32'd0, 32'd0, 1'b1, 32'd3, 32'h2A40, 1'b0);
        cycle("wr");
        chk("wr_const_idx", 128'(bus.index_o),            128'd9);
        chk("wr_const_tag", 128'(bus.fifo_data_o[63:32]), 128'hA);
        chk("wr_const_wr",  128'(bus.fifo_data_o[4]),     128'd1);

        // Almost-full blocks both channels, then release
        held_idx = bus.index_o;
        drive(1'b1, 32'd7, 32'h0000_0140, 1'b1, 32'd8, 32'h0000_0380, 1'b1);
        repeat (3) cycle("afull");
        chk("afull_hold_idx", 128'(bus.index_o), 128'(held_idx));
        bus.fifo_afull_i = 1'b0;
        cycle("afull_rel");

        // Asynchronous reset right after an acceptance
        drive(1'b1, 32'h77, 32'h0000_03C0, 1'b0, 32'd0, 32'd0, 1'b0);
        cycle("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wen",     128'(bus.fifo_write_en_o), 128'd0);
        chk("arst_data",    bus.fifo_data_o,           128'd0);
        chk("arst_idx",     128'(bus.index_o),         128'd0);
        chk("arst_arready", 128'(bus.arready_o),       128'd0);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        cycle("post_rst");
        drive(1'b1, 32'h99, 32'h0000_1240, 1'b1, 32'h98, 32'h0000_0080, 1'b0);
        cycle("post_rst_acc");

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom,
                  $urandom_range(0, 3) != 0, $urandom, $urandom,
                  $urandom_range(0, 4) == 0);
            cycle("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/index_extractor.md
INDEX_EXTRACTOR -- requirements
Module: index_extractor

Interface
REQ-001 SHALL have parameter OFFSET_BITS, default 6, meaning cache-line byte-offset width.
REQ-002 SHALL have parameter INDEX_BITS, default 4, meaning set-index width; index_o width equals INDEX_BITS.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 arid_i  input  32  read-request ID.
REQ-006 araddr_i  input  32  read-request byte address.
REQ-007 arvalid_i  input  1  read request valid.
REQ-008 arready_o  output  1  read request accepted this cycle.
REQ-009 awid_i  input  32  write-request ID.
REQ-010 awaddr_i  input  32  write-request byte address.
REQ-011 awvalid_i  input  1  write request valid.
REQ-012 awready_o  output  1  write request accepted this cycle.
REQ-013 index_o  output  4  set index of most recently accepted request.
REQ-014 fifo_afull_i  input  1  downstream FIFO almost full.
REQ-015 fifo_write_en_o  output  1  push strobe to downstream FIFO.
REQ-016 fifo_data_o  output  128  request descriptor pushed to FIFO.

Function
REQ-017 Index SHALL be addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS], i.e. addr[9:6]; tag SHALL be addr >> 10, zero-extended to 32 bits.
REQ-018 At most one request SHALL be accepted per cycle; arready_o/awready_o are combinational, never both 1.
REQ-019 When fifo_afull_i=1, arready_o and awready_o SHALL both be 0.
REQ-020 Only one valid, FIFO not almost full: that channel's ready SHALL be 1, the other 0.
REQ-021 Both valid, FIFO not almost full: round-robin; 1-bit last_grant register (0=read, 1=write) selects the channel not granted last; after reset, read wins first.
REQ-022 last_grant SHALL update only on an accepted handshake (valid & ready).
REQ-023 Accepted request SHALL produce, on the next rising edge, fifo_write_en_o=1 for exactly one cycle per acceptance (1-cycle latency, back-to-back allowed).
REQ-024 fifo_data_o layout: [127:96] ID, [95:64] address, [63:32] tag, [31:5] zero, [4] 1=write/0=read, [3:0] index.
REQ-025 fifo_data_o and index_o SHALL be registered, update only on acceptance, and hold their value otherwise.
REQ-026 fifo_write_en_o SHALL be 0 in any cycle following no acceptance.
REQ-027 Request not accepted SHALL be neither dropped nor recorded; the requester is responsible for holding valid.

Reset
REQ-028 rst_n=0 SHALL asynchronously clear fifo_write_en_o, fifo_data_o, index_o, last_grant to 0.
REQ-029 During reset arready_o and awready_o SHALL be 0; reset mid-operation cancels any pending push.
REQ-030 First acceptance possible on the first rising edge with rst_n=1.

Structure
REQ-031 Shared package SHALL hold OFFSET_BITS, INDEX_BITS, field bit positions of the 128-bit descriptor, and a descriptor typedef.
REQ-032 One sub-module, rr_arbiter2 (2-input round-robin arbiter with last_grant state), is natural; field extraction and output registers stay in the top.

Verification
REQ-033 Read only, araddr=0x1C0, arid=5 -> arready_o=1; next cycle fifo_write_en_o=1, index_o=7, data[4]=0, data[63:32]=0, data[127:96]=5.
REQ-034 Write only, awaddr=0x2A40, awid=3 -> awready_o=1; next cycle index_o=9, tag=0xA, data[4]=1.
REQ-035 Both valid for 3 cycles (araddr=200, awaddr=140) from reset -> grants read, write, read; index_o 3, 2, 3 on successive pushes.
REQ-036 fifo_afull_i=1 with both valid -> both ready 0, fifo_write_en_o stays 0, index_o unchanged; release -> acceptance resumes next edge.
REQ-037 Assert rst_n=0 between clock edges just after an acceptance -> fifo_write_en_o, fifo_data_o, index_o go 0 immediately; no push after release.
